custom_result_writer: RTL and testbench



---
 rtl/custom_result_writer_pkg.sv | 28 ++
 rtl/custom_wb_addr_gen.sv | 42 ++++
 rtl/custom_result_writer.sv | 124 ++++++++++++
 tb/tb_custom_result_writer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/custom_result_writer_pkg.sv
// Shared definitions for the accumulator write-back block: FSM state
// encoding, default geometry and the byte/write count helpers.
package custom_result_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wb_state_t;

    localparam int         DEF_NUM_ACC   = 4;
    localparam int         DEF_ACC_W     = 16;
    localparam int         DEF_ADDR_W    = 6;
    localparam logic [5:0] DEF_BASE_ADDR = 6'd48;

    // Bytes per accumulator result and byte writes per job.
    function automatic int calc_nb(input int acc_w);
        return acc_w / 8;
    endfunction

    function automatic int calc_nw(input int num_acc, input int acc_w);
        return num_acc * (acc_w / 8);
    endfunction

    localparam int NB = calc_nb(DEF_ACC_W);
    localparam int NW = calc_nw(DEF_NUM_ACC, DEF_ACC_W);

endpackage

// File: rtl/custom_wb_addr_gen.sv
// Write index counter for the result writer. Turns the running byte index
// into a wrapped memory address plus result/byte selects into the snapshot.
module custom_wb_addr_gen
    import custom_result_writer_pkg::*;
#(
    parameter int                NUM_ACC   = DEF_NUM_ACC,
    parameter int                ACC_W     = DEF_ACC_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  inc,
    output logic [ADDR_W-1:0]                     addr,
    output logic [$clog2(calc_nw(NUM_ACC, ACC_W)+1)-1:0] res_sel,
    output logic [$clog2(calc_nw(NUM_ACC, ACC_W)+1)-1:0] byte_sel,
    output logic                                  last
);

    localparam int NB_L  = calc_nb(ACC_W);
    localparam int NW_L  = calc_nw(NUM_ACC, ACC_W);
    localparam int IDX_W = $clog2(NW_L + 1);

    logic [IDX_W-1:0] idx;

    // Up-counter: restarts at job start, advances once per issued byte.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    // Address sum truncates to ADDR_W bits, which gives the modulo wrap.
    assign addr     = BASE_ADDR + ADDR_W'(idx);
    assign res_sel  = idx / IDX_W'(NB_L);
    assign byte_sel = idx % IDX_W'(NB_L);
    assign last     = (idx == IDX_W'(NW_L - 1));

endmodule

// File: rtl/custom_result_writer.sv
// Accumulator write-back: snapshots the PE results on a job request, clears
// the accumulator bank, streams the results little-endian into the scratch
// memory one byte per cycle and then holds a done flag until en drops.
module custom_result_writer
    import custom_result_writer_pkg::*;
#(
    parameter int                NUM_ACC   = DEF_NUM_ACC,
    parameter int                ACC_W     = DEF_ACC_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_ACC*ACC_W-1:0] acc_data_i,
    output logic                     acc_clr_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        addr_o,
    output logic [7:0]               mem_data_o,
    output logic                     is_done_o
);

    localparam int SNAP_W = NUM_ACC * ACC_W;
    localparam int IDX_W  = $clog2(calc_nw(NUM_ACC, ACC_W) + 1);

    wb_state_t          state, state_nxt;
    logic [SNAP_W-1:0]  snapshot, snapshot_nxt;
    logic               acc_clr_nxt, mem_we_nxt, is_done_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [7:0]         mem_data_nxt;

    logic               idx_clr, idx_inc, idx_last;
    logic [ADDR_W-1:0]  gen_addr;
    logic [IDX_W-1:0]   res_sel, byte_sel;
    logic [31:0]        bit_off;
    logic [SNAP_W-1:0]  snap_shifted;

    assign idx_clr = (state == ST_IDLE) && en;
    assign idx_inc = (state == ST_WRITE);

    custom_wb_addr_gen #(
        .NUM_ACC   (NUM_ACC),
        .ACC_W     (ACC_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (idx_clr),
        .inc      (idx_inc),
        .addr     (gen_addr),
        .res_sel  (res_sel),
        .byte_sel (byte_sel),
        .last     (idx_last)
    );

    // Byte selected from the snapshot; byte 0 of a result is its low byte.
    always_comb begin
        bit_off      = 32'(res_sel) * 32'(ACC_W) + 32'(byte_sel) * 32'd8;
        snap_shifted = snapshot >> bit_off;
    end

    // Next-state and next-output logic; address/data hold between writes.
    always_comb begin
        state_nxt    = state;
        snapshot_nxt = snapshot;
        acc_clr_nxt  = 1'b0;
        mem_we_nxt   = 1'b0;
        is_done_nxt  = 1'b0;
        addr_nxt     = addr_o;
        mem_data_nxt = mem_data_o;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    snapshot_nxt = acc_data_i;
                    acc_clr_nxt  = 1'b1;
                    state_nxt    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we_nxt   = 1'b1;
                addr_nxt     = gen_addr;
                mem_data_nxt = snap_shifted[7:0];
                if (idx_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // The first DONE edge always raises the flag, so a job whose
                // en dropped early still reports a one-cycle completion.
                if (!is_done_o || en) begin
                    is_done_nxt = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, snapshot and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            snapshot   <= '0;
            acc_clr_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            addr_o     <= '0;
            mem_data_o <= '0;
            is_done_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            snapshot   <= snapshot_nxt;
            acc_clr_o  <= acc_clr_nxt;
            mem_we_o   <= mem_we_nxt;
            addr_o     <= addr_nxt;
            mem_data_o <= mem_data_nxt;
            is_done_o  <= is_done_nxt;
        end
    end

endmodule

// File: tb/tb_custom_result_writer.sv
// Bench for custom_result_writer: two instances (base 48 and base 60) share
// the stimulus; expected memory writes are queued per instance when a job
// is launched and a negedge monitor pops and compares every write strobe.
module tb_custom_result_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [63:0] acc_data;

    logic        a_clr, a_we, a_done;
    logic [5:0]  a_addr;
    logic [7:0]  a_data;
    logic        b_clr, b_we, b_done;
    logic [5:0]  b_addr;
    logic [7:0]  b_data;

    int total  = 0;
    int passed = 0;

    logic [13:0] q_a[$];
    logic [13:0] q_b[$];

    always #5 clk = ~clk;

    custom_result_writer dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .acc_data_i (acc_data),
        .acc_clr_o  (a_clr),
        .mem_we_o   (a_we),
        .addr_o     (a_addr),
        .mem_data_o (a_data),
        .is_done_o  (a_done)
    );

    custom_result_writer #(.BASE_ADDR(6'd60)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .acc_data_i (acc_data),
        .acc_clr_o  (b_clr),
        .mem_we_o   (b_we),
        .addr_o     (b_addr),
        .mem_data_o (b_data),
        .is_done_o  (b_done)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: result j byte b goes to base + 2j + b (mod 64),
    // carrying bits [16j+8b +: 8] of the flat accumulator word.
    task automatic push_job(input logic [63:0] d);
        for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < 2; b++) begin
                int k;
                logic [7:0] v;
                k = j * 2 + b;
                v = 8'((d >> (16 * j + 8 * b)) & 64'hFF);
                q_a.push_back({6'((48 + k) % 64), v});
                q_b.push_back({6'((60 + k) % 64), v});
            end
        end
    endtask

    // Control outputs {clr, we, done} of both instances.
    task automatic chk_ctrl(input string name, input logic clr,
                            input logic we, input logic done);
        chk({name, "_a"}, {29'd0, a_clr, a_we, a_done}, {29'd0, clr, we, done});
        chk({name, "_b"}, {29'd0, b_clr, b_we, b_done}, {29'd0, clr, we, done});
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (a_we) begin
            if (q_a.size() == 0) begin
                total++;
                $display("FAIL a_extra_write: got addr %0d data %0h, required no write",
                         a_addr, a_data);
            end else begin
                chk("a_write", {18'd0, a_addr, a_data}, {18'd0, q_a.pop_front()});
            end
        end
        if (b_we) begin
            if (q_b.size() == 0) begin
                total++;
                $display("FAIL b_extra_write: got addr %0d data %0h, required no write",
                         b_addr, b_data);
            end else begin
                chk("b_write", {18'd0, b_addr, b_data}, {18'd0, q_b.pop_front()});
            end
        end
    end

    // One job from the start request to the return to IDLE.
    task automatic run_job(input logic [63:0] d, input bit drop_mid,
                           input bit change_mid, input int hold);
        acc_data = d;
        push_job(d);
        en = 1'b1;
        tick();                               // E0 taken
        chk_ctrl("start_clr", 1'b1, 1'b0, 1'b0);
        if (change_mid) acc_data = '1;
        if (drop_mid)   en = 1'b0;
        tick();                               // E1: first write
        chk_ctrl("first_write", 1'b0, 1'b1, 1'b0);
        repeat (7) tick();                    // E8: last write
        chk_ctrl("last_write", 1'b0, 1'b1, 1'b0);
        tick();                               // E9
        chk_ctrl("done_rise", 1'b0, 1'b0, 1'b1);
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        if (!drop_mid) begin
            for (int i = 0; i < hold; i++) begin
                tick();
                chk_ctrl("done_hold", 1'b0, 1'b0, 1'b1);
            end
            en = 1'b0;
        end
        tick();
        chk_ctrl("done_fall", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        acc_data = '0;
        tick();
        tick();
        chk_ctrl("reset_ctrl", 1'b0, 1'b0, 1'b0);
        chk("reset_a_addr_data", {18'd0, a_addr, a_data}, 32'd0);
        chk("reset_b_addr_data", {18'd0, b_addr, b_data}, 32'd0);
        rst = 1'b0;
        tick();
        chk_ctrl("idle_ctrl", 1'b0, 1'b0, 1'b0);

        // Directed jobs: basic, input changes after start, held done.
        run_job(64'h4433_2211_BEEF_1234, 1'b0, 1'b0, 0);
        run_job(64'h4433_2211_BEEF_1234, 1'b0, 1'b1, 0);
        run_job(64'h0102_0304_0506_0708, 1'b0, 1'b0, 3);
        run_job(64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 1'b0, 1);

        // Reset after the third write: nothing further may be written.
        acc_data = 64'hDEAD_BEEF_CAFE_F00D;
        push_job(acc_data);
        en = 1'b1;
        tick();                               // E0
        en = 1'b0;
        tick();
        tick();
        tick();                               // third write visible
        rst = 1'b1;
        tick();
        chk_ctrl("midjob_rst", 1'b0, 1'b0, 1'b0);
        chk("midjob_rst_a_addr", {26'd0, a_addr}, 32'd0);
        chk("midjob_rst_b_addr", {26'd0, b_addr}, 32'd0);
        q_a.delete();
        q_b.delete();
        rst = 1'b0;
        tick();
        tick();
        chk_ctrl("post_rst_idle", 1'b0, 1'b0, 1'b0);
        run_job(64'h4433_2211_BEEF_1234, 1'b0, 1'b0, 0);

        // en dropped during WRITE: full job, one-cycle done pulse.
        run_job(64'h1122_3344_5566_7788, 1'b1, 1'b0, 0);
        tick();
        chk_ctrl("after_pulse_idle", 1'b0, 1'b0, 1'b0);

        // Randomized jobs.
        for (int r = 0; r < 8; r++) begin
            logic [63:0] d;
            d = {$urandom(), $urandom()};
            run_job(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        chk("final_a_queue_empty", q_a.size(), 0);
        chk("final_b_queue_empty", q_b.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
